// File: rtl/addsub_pkg.sv
// Shared definitions for the byte-serial adder/subtractor: FSM states, byte width
// and the index-width helper.
package addsub_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      r = ((1 << i) < n) ? (i + 1) : r;
    end
    return r;
  endfunction

endpackage

// File: rtl/byte_csel_adder.sv
// 8-bit combinational carry-select adder: the upper nibble is computed for both
// carry values and selected by the lower-nibble carry.
module byte_csel_adder
  import addsub_pkg::*;
(
  input  logic [BYTE_W-1:0] a_i,
  input  logic [BYTE_W-1:0] b_i,
  input  logic              c_i,
  output logic [BYTE_W-1:0] sum_o,
  output logic              cout_o,
  output logic              c_msb_o
);

  logic [4:0] lo_s;
  logic [4:0] hi0_s;
  logic [4:0] hi1_s;

  assign lo_s  = {1'b0, a_i[3:0]} + {1'b0, b_i[3:0]} + {4'b0000, c_i};
  assign hi0_s = {1'b0, a_i[7:4]} + {1'b0, b_i[7:4]};
  assign hi1_s = {1'b0, a_i[7:4]} + {1'b0, b_i[7:4]} + 5'd1;

  assign sum_o  = {(lo_s[4] ? hi1_s[3:0] : hi0_s[3:0]), lo_s[3:0]};
  assign cout_o = lo_s[4] ? hi1_s[4] : hi0_s[4];
  // Carry into bit 7 recovered from the sum bit and its operands.
  assign c_msb_o = sum_o[7] ^ a_i[7] ^ b_i[7];

endmodule

// File: rtl/addsub_byte_seq.sv
// W-bit add (or subtract with ADDSUB_SUB_EN defined) computed one byte per cycle,
// LSB first, on a single shared byte adder, with valid/ready handshakes.
module addsub_byte_seq
  import addsub_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BYTE_W*NBYTES-1:0] a,
  input  logic [BYTE_W*NBYTES-1:0] b,
  input  logic                     cin,
`ifdef ADDSUB_SUB_EN
  input  logic                     op_sub,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BYTE_W*NBYTES-1:0] sum,
  output logic                     cout,
  output logic                     ovf,
  output logic                     busy
);

  localparam int W     = BYTE_W * NBYTES;
  localparam int IDX_W = clog2(NBYTES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [W-1:0]     sum_q;
  logic             carry_q;
  logic             cout_q;
  logic             ovf_q;
  logic             out_valid_q;
  logic             in_ready_q;
  logic             busy_q;
`ifdef ADDSUB_SUB_EN
  logic             op_sub_q;
`endif

  logic [W-1:0]      sum_d;
  logic [BYTE_W-1:0] a_byte_s;
  logic [BYTE_W-1:0] b_byte_s;
  logic [BYTE_W-1:0] add_b_s;
  logic [BYTE_W-1:0] byte_sum_s;
  logic              byte_cout_s;
  logic              byte_cmsb_s;

  // Select the current operand bytes and splice the new sum byte into place.
  always_comb begin
    a_byte_s = '0;
    b_byte_s = '0;
    sum_d    = sum_q;
    for (int i = 0; i < NBYTES; i++) begin
      a_byte_s = (idx_q == IDX_W'(i)) ? a_q[i*BYTE_W +: BYTE_W] : a_byte_s;
      b_byte_s = (idx_q == IDX_W'(i)) ? b_q[i*BYTE_W +: BYTE_W] : b_byte_s;
      sum_d[i*BYTE_W +: BYTE_W] = (idx_q == IDX_W'(i)) ? byte_sum_s
                                                        : sum_q[i*BYTE_W +: BYTE_W];
    end
`ifdef ADDSUB_SUB_EN
    add_b_s = op_sub_q ? ~b_byte_s : b_byte_s;
`else
    add_b_s = b_byte_s;
`endif
  end

  byte_csel_adder u_byte_add (
    .a_i     (a_byte_s),
    .b_i     (add_b_s),
    .c_i     (carry_q),
    .sum_o   (byte_sum_s),
    .cout_o  (byte_cout_s),
    .c_msb_o (byte_cmsb_s)
  );

  // Control FSM with registered outputs; out_valid rises one cycle after DONE entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
`ifdef ADDSUB_SUB_EN
      op_sub_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            idx_q      <= '0;
`ifdef ADDSUB_SUB_EN
            op_sub_q   <= op_sub;
            carry_q    <= op_sub ? 1'b1 : cin;
`else
            carry_q    <= cin;
`endif
            state_q    <= ST_RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end else begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end
        end
        ST_RUN: begin
          sum_q   <= sum_d;
          carry_q <= byte_cout_s;
          if (idx_q == IDX_LAST) begin
            idx_q   <= '0;
            cout_q  <= byte_cout_s;
            ovf_q   <= byte_cmsb_s ^ byte_cout_s;
            state_q <= ST_DONE;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_DONE: begin
          if (out_valid_q && out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            out_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          idx_q       <= '0;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_addsub_byte_seq.sv
// Scoreboard bench for addsub_byte_seq (NBYTES=4); subtract vectors run when
// ADDSUB_SUB_EN is defined.
module tb_addsub_byte_seq;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
`ifdef ADDSUB_SUB_EN
  logic         op_sub = 1'b0;
`endif
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  logic ov_prev = 1'b0;

  addsub_byte_seq #(.NBYTES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef ADDSUB_SUB_EN
    .op_sub    (op_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: latency on out_valid rise, result compare on each handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && !ov_prev) chk("latency", 64'(cyc - acc_cyc), 64'd5);
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_result: sum 0x%0h with empty scoreboard", sum);
      end else begin
        e = sb.pop_front();
        chk("sum", {32'd0, sum}, {32'd0, e.s});
        chk("cout", {63'd0, cout}, {63'd0, e.c});
        chk("ovf", {63'd0, ovf}, {63'd0, e.v});
      end
    end
    ov_prev = out_valid;
  end

  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                       input bit push, input logic [W-1:0] es, input logic ec, input logic ev);
    int k;
    exp_t x;
    k = 0;
    while (!in_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (!in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL ready_timeout: in_ready 0 expected 1");
    end
    a = ta;
    b = tb_;
    cin = tc;
    in_valid = 1'b1;
    x.s = es;
    x.c = ec;
    x.v = ev;
    if (push) sb.push_back(x);
    @(posedge clk); #1;
    acc_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL result_timeout: %0d results pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  logic [W-1:0] va[6] = '{32'h000000FF, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h12345678, 32'h0000FF00};
  logic [W-1:0] vb[6] = '{32'h00000001, 32'h00000000, 32'h00000001, 32'h80000000, 32'h11111111, 32'h00000100};
  logic         vc[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [W-1:0] vs[6] = '{32'h00000100, 32'h00000000, 32'h80000000, 32'h00000000, 32'h2345678A, 32'h00010000};
  logic         vco[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic         vov[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_sum", {32'd0, sum}, 64'd0);
    chk("rst_cout", {63'd0, cout}, 64'd0);
    chk("rst_ovf", {63'd0, ovf}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      issue(va[i], vb[i], vc[i], 1'b1, vs[i], vco[i], vov[i]);
      if (i == 0) begin
        chk("run_busy", {63'd0, busy}, 64'd1);
        chk("run_in_ready", {63'd0, in_ready}, 64'd0);
      end
      wait_empty();
    end

`ifdef ADDSUB_SUB_EN
    op_sub = 1'b1;
    issue(32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    wait_empty();
    issue(32'd7, 32'd5, 1'b1, 1'b1, 32'h00000002, 1'b1, 1'b0);
    wait_empty();
    issue(32'h80000000, 32'd1, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
    wait_empty();
    op_sub = 1'b0;
`endif

    // Backpressure: hold the result for 10 cycles while a stray request is offered.
    out_ready = 1'b0;
    issue(32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
    for (int k = 0; k < 20 && !out_valid; k++) begin
      @(posedge clk); #1;
    end
    for (int k = 0; k < 10; k++) begin
      a = 32'h00000123;
      in_valid = 1'b1;
      @(posedge clk); #1;
      chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      chk("bp_sum_held", {32'd0, sum}, 64'h00000000FFFFFFFF);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hs_in_ready", {63'd0, in_ready}, 64'd1);
    chk("hs_out_valid", {63'd0, out_valid}, 64'd0);
    chk("hs_drained", 64'(sb.size()), 64'd0);
    issue(32'h00000001, 32'h00000002, 1'b0, 1'b1, 32'h00000003, 1'b0, 1'b0);
    wait_empty();

    // Reset two bytes into a run: no result may appear.
    issue(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
    chk("abort_sum", {32'd0, sum}, 64'd0);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk("abort_no_valid", {63'd0, out_valid}, 64'd0);
    end
    issue(32'h01010101, 32'h02020202, 1'b0, 1'b1, 32'h03030303, 1'b0, 1'b0);
    wait_empty();

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
